// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: FSM state codes and base opcodes.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory request-ready handshake between sequencer and memories.
interface multicycle_sequencer_if;
  logic o_IMemReq;
  logic i_IMemReady;
  logic o_DMemReq;
  logic o_DMemWe;
  logic i_DMemReady;

  modport master (output o_IMemReq, o_DMemReq, o_DMemWe,
                  input  i_IMemReady, i_DMemReady);
  modport slave  (input  o_IMemReq, o_DMemReq, o_DMemWe,
                  output i_IMemReady, i_DMemReady);
endinterface

// File: rtl/mem_wait_timer.sv
// 8-bit data-memory wait counter; expired_o flags the cycle that reaches TIMEOUT waits.
module mem_wait_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q counts earlier waits, so +1 includes the current unready cycle
  assign expired_o = (cnt_q + 8'd1) == TIMEOUT;
endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV control sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky faults.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Run,
  input  logic [6:0]  iv_OpCode,
  input  logic        i_Mem_Read,
  input  logic        i_Mem_Write,
  input  logic        i_Reg_Write,
  multicycle_sequencer_if.master bus,
  output logic        o_IRWrite,
  output logic        o_RegWriteEn,
  output logic        o_PCWrite,
  output logic        o_Illegal,
  output logic        o_BusErr,
  output logic [2:0]  ov_State,
  output logic [31:0] ov_InstRet
);
  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        buserr_q, buserr_d;
  logic        expired;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (i_Clk),
    .rst_i     (i_Reset),
    .clr_i     (state_q != S_MEM),
    .en_i      (state_q == S_MEM && !bus.i_DMemReady),
    .expired_o (expired)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      buserr_q  <= buserr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    buserr_d  = buserr_q;
    case (state_q)
      S_FETCH:  if (i_Run && bus.i_IMemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (is_legal_op(iv_OpCode)) state_d = S_EXEC;
        else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (i_Mem_Read || i_Mem_Write) state_d = S_MEM;
        else if (i_Reg_Write)          state_d = S_WB;
        else                           state_d = S_FETCH;
      end
      // ready beats a coincident timeout
      S_MEM: begin
        if (bus.i_DMemReady) state_d = i_Mem_Read ? S_WB : S_FETCH;
        else if (expired) begin
          state_d  = S_HALT;
          buserr_d = 1'b1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
  end

  // enables are suppressed while reset is asserted so no stale pulse leaks out
  always_comb begin
    bus.o_IMemReq = 1'b0;
    bus.o_DMemReq = 1'b0;
    bus.o_DMemWe  = 1'b0;
    o_IRWrite     = 1'b0;
    o_RegWriteEn  = 1'b0;
    o_PCWrite     = 1'b0;
    if (!i_Reset) begin
      case (state_q)
        S_FETCH: begin
          bus.o_IMemReq = i_Run;
          o_IRWrite     = i_Run && bus.i_IMemReady;
        end
        S_EXEC:  o_PCWrite = !(i_Mem_Read || i_Mem_Write || i_Reg_Write);
        S_MEM: begin
          bus.o_DMemReq = 1'b1;
          bus.o_DMemWe  = i_Mem_Write;
          o_PCWrite     = bus.i_DMemReady && !i_Mem_Read;
        end
        S_WB: begin
          o_RegWriteEn = 1'b1;
          o_PCWrite    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instret_d  = instret_q + (o_PCWrite ? 32'd1 : 32'd0);
  assign o_Illegal  = illegal_q;
  assign o_BusErr   = buserr_q;
  assign ov_State   = state_q;
  assign ov_InstRet = instret_q;
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The parameter MEM_TIMEOUT SHALL default to 8'd255 and set the number of cycles MEM waits for i_DMemReady before declaring a bus error.
REQ-002 The port i_Clk SHALL be input, width 1, and is the single clock; all state updates occur on its rising edge.
REQ-003 The port i_Reset SHALL be input, width 1, and is a synchronous, active-high reset.
REQ-004 The port i_Run SHALL be input, width 1, and permits a new instruction fetch when high.
REQ-005 The port iv_OpCode SHALL be input, width 7, carrying IR[6:0], which is stable from DECODE onward.
REQ-006 The ports i_Mem_Read, i_Mem_Write and i_Reg_Write SHALL be inputs, width 1 each, carrying the decoded control bits for iv_OpCode.
REQ-007 The ports i_IMemReady and i_DMemReady SHALL be inputs, width 1 each, carrying the instruction and data memory ready handshakes.
REQ-008 The ports o_IMemReq, o_IRWrite, o_DMemReq, o_DMemWe, o_RegWriteEn and o_PCWrite SHALL be outputs, width 1 each, and act as datapath enables.
REQ-009 The ports o_Illegal and o_BusErr SHALL be outputs, width 1 each, and are sticky fault flags.
REQ-010 The port ov_State SHALL be output, width 3, exposing the current FSM state.
REQ-011 The port ov_InstRet SHALL be output, width 32, holding the retired-instruction count.

Function
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT with o_Illegal=1.
REQ-013 In FETCH, o_IMemReq SHALL equal i_Run; when i_Run and i_IMemReady are both high, o_IRWrite SHALL pulse for 1 cycle and the next state SHALL be DECODE; otherwise the FSM SHALL remain in FETCH.
REQ-014 DECODE SHALL last exactly 1 cycle and go to EXEC if iv_OpCode is one of 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33; otherwise it SHALL go to HALT and set o_Illegal.
REQ-015 EXEC SHALL last exactly 1 cycle with priority: (i_Mem_Read|i_Mem_Write) to MEM; else i_Reg_Write to WB; else to FETCH, asserting o_PCWrite in that cycle.
REQ-016 In MEM, o_DMemReq SHALL be 1 and o_DMemWe SHALL equal i_Mem_Write; on i_DMemReady, a load SHALL go to WB and a store SHALL go to FETCH, asserting o_PCWrite.
REQ-017 An 8-bit wait counter SHALL clear on MEM entry and increment each MEM cycle without ready; when it equals MEM_TIMEOUT without ready, the FSM SHALL go to HALT and set o_BusErr.
REQ-018 If i_DMemReady arrives in the same cycle as the timeout, ready SHALL win and no error SHALL be raised.
REQ-019 WB SHALL last exactly 1 cycle with o_RegWriteEn=1 and o_PCWrite=1, then go to FETCH.
REQ-020 ov_InstRet SHALL increment by 1 on every cycle where o_PCWrite=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 HALT SHALL be absorbing until reset, with all enables 0 and fault flags held.
REQ-022 Latencies SHALL be, with zero memory wait: ALU/jump instructions 4 cycles (FETCH-DECODE-EXEC-WB), branches 3 cycles, stores 4 cycles, loads 5 cycles.
REQ-023 All enables SHALL be decoded combinationally from the state and inputs; the state, counters and flags SHALL be registered.
REQ-024 When i_Run drops mid-instruction, the current instruction SHALL complete and the FSM SHALL stall only in FETCH.

Reset
REQ-025 When i_Reset=1 at a clock edge, the state SHALL become FETCH, and ov_InstRet, the wait counter, o_Illegal and o_BusErr SHALL become 0; this overrides any state, including HALT and mid-MEM.
REQ-026 During the reset cycle and the cycle after, no o_PCWrite, o_RegWriteEn or o_IRWrite pulse SHALL occur unless FETCH conditions hold post-reset.

Structure
REQ-027 Opcode constants and state encodings SHALL live in the shared riscv_pkg package, alongside the control-unit opcode values.
REQ-028 The block SHALL contain a single sub-module, mem_wait_timer, implementing the 8-bit counter with clear, enable and expired outputs.

Verification
REQ-029 Scenario: i_Run=1, ready always 1, opcode 0x33 with i_Reg_Write=1 -> states 0,1,2,4,0; o_RegWriteEn and o_PCWrite high in cycle 4; ov_InstRet=1.
REQ-030 Scenario: load 0x03 with i_DMemReady delayed 3 cycles -> MEM held 4 cycles, then WB; ov_InstRet increments once.
REQ-031 Scenario: store 0x23 with i_DMemReady never asserted -> HALT after 255 MEM cycles, o_BusErr=1, no o_PCWrite.
REQ-032 Scenario: opcode 0x7F -> HALT after DECODE with o_Illegal=1; asserting i_Reset -> FETCH with flags cleared.
REQ-033 Scenario: branch 0x63 -> o_PCWrite in EXEC, total 3 cycles; preload the count to 0xFFFFFFFF -> it wraps to 0.
REQ-034 Scenario: i_Reset asserted in MEM -> FETCH next cycle, no write enables, counter cleared.
